// File: rtl/sdp_ram_clr.sv
// Simple dual-port RAM with byte enables, registered reads and a clear engine that zeroes every word.
// Optional macro SDP_RAM_OUTREG_EN adds a second output register stage, giving a read latency of 2.
module sdp_ram_clr #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_NEW     = 1
) (
    input  logic                    wclk,
    input  logic                    rst_n,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   d_in,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   d_out,
    output logic                    d_valid
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic [DATA_WIDTH-1:0]   d_out_q, d_out_d;
    logic                    d_valid_q, d_valid_d;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    waddr_ok_s, raddr_ok_s;
    logic [DATA_WIDTH-1:0]   old_wword_s, merged_s, rword_s;
    logic                    wr_fire_s, rd_fire_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_addr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    // Full-depth arrays cover every address, so the range check only exists for odd depths.
    generate
        if (RAM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full
            assign waddr_ok_s = 1'b1;
            assign raddr_ok_s = 1'b1;
        end else begin : g_partial
            assign waddr_ok_s = ({1'b0, waddr} < DEPTH_W);
            assign raddr_ok_s = ({1'b0, raddr} < DEPTH_W);
        end
    endgenerate

    // Byte merge of incoming data onto the currently stored word.
    always_comb begin
        old_wword_s = waddr_ok_s ? mem[waddr] : '0;
        merged_s    = old_wword_s;
        for (int i = 0; i < NB; i++) begin
            merged_s[8*i +: 8] = be[i] ? d_in[8*i +: 8] : old_wword_s[8*i +: 8];
        end
    end

    // Next-state, clear sequencing and memory write port selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_fire_s   = 1'b0;
        rd_fire_s   = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = cnt_q;
        mem_wdata_s = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = cnt_q;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else begin
                    wr_fire_s   = we && waddr_ok_s && (be != '0);
                    rd_fire_s   = re;
                    mem_we_s    = wr_fire_s;
                    mem_addr_s  = waddr;
                    mem_wdata_s = merged_s;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Read data: out-of-range reads give zero; same-address collisions follow RD_NEW.
    always_comb begin
        if (!raddr_ok_s) begin
            rword_s = '0;
        end else if ((RD_NEW != 0) && wr_fire_s && (raddr == waddr)) begin
            rword_s = merged_s;
        end else begin
            rword_s = mem[raddr];
        end
    end

    // Storage array; contents are only initialised by the clear engine.
    always_ff @(posedge wclk) begin
        if (mem_we_s) begin
            mem[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Control state registers.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SDP_RAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
    logic                  s1_valid_q, s1_valid_d;

    // Two-stage output path; the final register only moves when stage one holds a read.
    always_comb begin
        s1_data_d  = rd_fire_s ? rword_s : s1_data_q;
        s1_valid_d = rd_fire_s;
        d_out_d    = s1_valid_q ? s1_data_q : d_out_q;
        d_valid_d  = s1_valid_q;
    end

    // First output stage registers.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end
`else
    // Single output stage; d_out holds when no read is accepted.
    always_comb begin
        d_out_d   = rd_fire_s ? rword_s : d_out_q;
        d_valid_d = rd_fire_s;
    end
`endif

    // Output registers.
    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_q   <= '0;
            d_valid_q <= 1'b0;
        end else begin
            d_out_q   <= d_out_d;
            d_valid_q <= d_valid_d;
        end
    end

    assign busy    = busy_q;
    assign d_out   = d_out_q;
    assign d_valid = d_valid_q;

endmodule

// File: tb/tb_sdp_ram_clr.sv
// Scoreboard bench for sdp_ram_clr: randomised and directed traffic against an array reference model.
module tb_sdp_ram_clr;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int RDN   = 1;
    localparam int NB    = DW / 8;
`ifdef SDP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          wclk    = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clr_req = 1'b0;
    logic          we      = 1'b0;
    logic          re      = 1'b0;
    logic [AW-1:0] waddr   = '0;
    logic [AW-1:0] raddr   = '0;
    logic [NB-1:0] be      = '0;
    logic [DW-1:0] d_in    = '0;
    logic          busy;
    logic          d_valid;
    logic [DW-1:0] d_out;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t          sbq[$];
    exp_t          mon_e;
    logic [DW-1:0] model [DEPTH];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;

    sdp_ram_clr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH),
        .RD_NEW    (RDN)
    ) dut (
        .wclk   (wclk),
        .rst_n  (rst_n),
        .clr_req(clr_req),
        .busy   (busy),
        .we     (we),
        .waddr  (waddr),
        .be     (be),
        .d_in   (d_in),
        .re     (re),
        .raddr  (raddr),
        .d_out  (d_out),
        .d_valid(d_valid)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                            input logic [NB-1:0] b);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (b[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // One accepted cycle; expectation comes from the model unless a constant is supplied.
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [NB-1:0] b,
                         input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ra,
                         input logic use_c, input logic [DW-1:0] cval);
        exp_t e;
        we = w; waddr = wa; be = b; d_in = d; re = r; raddr = ra;
        if (r) begin
            if (use_c) e.data = cval;
            else if (w && (wa == ra) && (RDN != 0)) e.data = merge(model[ra], d, b);
            else e.data = model[ra];
            e.cyc = cyc + LAT;
            sbq.push_back(e);
        end
        if (w) model[wa] = merge(model[wa], d, b);
        step();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic wait_clear(input string name, input logic noise);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            if (noise) begin
                we = 1'b1; be = '1;
                waddr = AW'($urandom_range(0, DEPTH - 1));
                d_in = DW'($urandom);
                re = 1'b1;
            end
            step();
        end
        we = 1'b0; re = 1'b0;
        checks++;
        if (n != DEPTH) begin
            failures++;
            $display("FAIL %s busy_cycles actual=%0d required=%0d", name, n, DEPTH);
        end
        model_zero();
    endtask

    // Monitor: every d_valid pulse must match the oldest outstanding expectation, on time.
    always @(negedge wclk) begin
        if (rst_n === 1'b1 && d_valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=%h required=none", d_out);
            end else begin
                mon_e = sbq.pop_front();
                if (d_out !== mon_e.data || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL read_data actual=%h@%0d required=%h@%0d",
                             d_out, cyc, mon_e.data, mon_e.cyc);
                end
            end
        end
    end

    initial begin
        model_zero();
        repeat (3) step();
        check("reset_dout", d_out, '0);
        check("reset_dvalid", DW'(d_valid), '0);
        check("reset_busy", DW'(busy), DW'(1));
        rst_n = 1'b1;
        wait_clear("reset_clear", 1'b0);

        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, 16'h0000);

        drive(1'b1, 3'd5, 2'b11, 16'hA5C3, 1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd5, 1'b1, 16'hA5C3);

        drive(1'b1, 3'd2, 2'b11, 16'h1234, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 3'd2, 2'b01, 16'hFFFF, 1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd2, 1'b1, 16'h12FF);

        drive(1'b1, 3'd3, 2'b11, 16'h1111, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 3'd3, 2'b11, 16'hBEEF, 1'b1, 3'd3, 1'b1, (RDN != 0) ? 16'hBEEF : 16'h1111);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd3, 1'b1, 16'hBEEF);

        repeat (300) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), NB'($urandom),
                  DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                  1'b0, '0);
        end

        for (int a = 0; a < DEPTH; a++) drive(1'b1, AW'(a), 2'b11, 16'h5555, 1'b0, '0, 1'b0, '0);
        clr_req = 1'b1; we = 1'b1; waddr = 3'd1; be = 2'b11; d_in = 16'hDEAD; re = 1'b1; raddr = 3'd1;
        step();
        clr_req = 1'b0; we = 1'b0; re = 1'b0;
        check("clr_busy_rise", DW'(busy), DW'(1));
        wait_clear("clr_req_clear", 1'b1);
        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, 16'h0000);

        drive(1'b1, 3'd1, 2'b11, 16'h7E7E, 1'b0, '0, 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b1, 16'h7E7E);
        repeat (3) step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midclr_reset_dout", d_out, '0);
        check("midclr_reset_dvalid", DW'(d_valid), '0);
        check("midclr_reset_busy", DW'(busy), DW'(1));
        step();
        rst_n = 1'b1;
        wait_clear("midclr_restart", 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 3'd1, 1'b1, 16'h0000);
        repeat (40) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), NB'($urandom),
                  DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)),
                  1'b0, '0);
        end

        repeat (5) step();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL missing_reads actual=%0d required=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
